// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV64 instruction encoder.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      ENC_R  = 3'd0,
      ENC_I  = 3'd1,
      ENC_S  = 3'd2,
      ENC_B  = 3'd3,
      ENC_U  = 3'd4,
      ENC_J  = 3'd5,
      ENC_LI = 3'd6
   } enc_kind_t;

   localparam logic [6:0]  OPC_LUI     = 7'h37;
   localparam logic [6:0]  OPC_OPIMM   = 7'h13;
   localparam logic [6:0]  OPC_OPIMM32 = 7'h1B;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   // Enum value doubles as the bit index in the per-request step mask.
   typedef enum logic [2:0] {
      LI_LUI     = 3'd0,
      LI_ADDIW   = 3'd1,
      LI_SLLI11A = 3'd2,
      LI_ADDI_C2 = 3'd3,
      LI_SLLI11B = 3'd4,
      LI_ADDI_C1 = 3'd5,
      LI_SLLI10  = 3'd6,
      LI_ADDI_C0 = 3'd7
   } li_step_t;

   localparam int LI_STEPS = 8;

   // True when every bit of v above msb is a copy of bit msb.
   function automatic logic sext_ok(input logic [63:0] v, input int msb);
      logic [63:0] s;
      s = $signed(v) >>> msb;
      return (s == '0) || (s == '1);
   endfunction

   function automatic logic [63:0] sext12(input logic [11:0] v);
      return {{52{v[11]}}, v};
   endfunction

   // Lowest enabled step at or above index 'from'; LI_ADDI_C0 if none.
   function automatic li_step_t next_step(input logic [LI_STEPS-1:0] m, input int from);
      li_step_t s;
      s = LI_ADDI_C0;
      for (int i = LI_STEPS - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) s = li_step_t'(i[2:0]);
      end
      return s;
   endfunction

endpackage

// File: rtl/instr_encoder_format.sv
// Combinational RV field packer: kind + fields + 64-bit immediate -> 32-bit word.
// With INSTR_ENCODER_RANGE_CHECK_EN defined, flags immediates that do not fit their field.
module instr_format
   import instr_encoder_pkg::*;
(
   input  enc_kind_t   kind_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  f3_i,
   input  logic [6:0]  f7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [63:0] imm_i,
   output logic [31:0] word_o,
   output logic        err_o
);

   always_comb begin
      word_o = '0;
      case (kind_i)
         ENC_R:   word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
         ENC_I:   word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
         ENC_S:   word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
         ENC_B:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
         ENC_U:   word_o = {imm_i[31:12], rd_i, opcode_i};
         ENC_J:   word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         default: word_o = '0;
      endcase
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   always_comb begin
      err_o = 1'b0;
      case (kind_i)
         ENC_I, ENC_S: err_o = !sext_ok(imm_i, 11);
         ENC_B:        err_o = !sext_ok(imm_i, 12);
         ENC_J:        err_o = !sext_ok(imm_i, 20);
         ENC_U:        err_o = !sext_ok(imm_i, 31);
         default:      err_o = 1'b0;
      endcase
   end
`else
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm_i[63:32];
   assign err_o         = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Valid/ready encoder turning structured requests into RV64 words, expanding LI into
// lui/addiw/slli/addi. Optional immediate range flag: define INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_kind,
   input  logic [6:0]  req_opcode,
   input  logic [2:0]  req_f3,
   input  logic [6:0]  req_f7,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [63:0] req_imm,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic        instr_last,
   output logic        instr_err
);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t              state_q, state_d;
   li_step_t            step_q, step_d;
   enc_kind_t           kind_in, kind_q;
   logic [6:0]          op_q, f7_q;
   logic [2:0]          f3_q;
   logic [4:0]          rd_q, rs1_q, rs2_q;
   logic [63:0]         imm_q;
   logic                li_q, small_q, nop_q;
   logic [19:0]         hi20_q, hi20_d;
   logic [11:0]         lo12_q, lo12_d;
   logic [LI_STEPS-1:0] mask_q, mask_d;
   li_step_t            first_d;
   logic                li_in, nop_d, small_d, fits32;
   logic [31:0]         u32;
   logic                emit, last, hs, accept;

   assign kind_in = enc_kind_t'(req_kind);

   // Plan for the incoming request. Non-LI requests reuse the single C0 slot so
   // that "last" falls out of the same mask logic.
   always_comb begin
      li_in   = (kind_in == ENC_LI);
      fits32  = sext_ok(req_imm, 31);
      nop_d   = li_in && (req_rd == '0);
      small_d = li_in && (nop_d || sext_ok(req_imm, 11));
      u32     = fits32 ? req_imm[31:0] : req_imm[63:32];
      hi20_d  = 20'((u32 + 32'h800) >> 12);
      lo12_d  = u32[11:0];
      mask_d  = '0;
      if (!li_in || small_d) begin
         mask_d[LI_ADDI_C0] = 1'b1;
      end else begin
         mask_d[LI_LUI]   = 1'b1;
         mask_d[LI_ADDIW] = !(SKIP_ZERO && (lo12_d == '0));
         if (!fits32) begin
            mask_d[LI_SLLI11A] = 1'b1;
            mask_d[LI_SLLI11B] = 1'b1;
            mask_d[LI_SLLI10]  = 1'b1;
            mask_d[LI_ADDI_C2] = !(SKIP_ZERO && (req_imm[31:21] == '0));
            mask_d[LI_ADDI_C1] = !(SKIP_ZERO && (req_imm[20:10] == '0));
            mask_d[LI_ADDI_C0] = !(SKIP_ZERO && (req_imm[9:0] == '0));
         end
      end
      first_d = next_step(mask_d, 0);
   end

   always_comb begin
      emit      = (state_q == S_EMIT);
      last      = ((mask_q >> step_q) >> 1) == '0;
      hs        = emit && instr_ready;
      req_ready = !emit || (hs && last);
      accept    = req_valid && req_ready;
      state_d   = state_q;
      step_d    = step_q;
      if (accept) begin
         state_d = S_EMIT;
         step_d  = first_d;
      end else if (hs) begin
         if (last) state_d = S_IDLE;
         else      step_d  = next_step(mask_q, int'(step_q) + 1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         step_q  <= LI_LUI;
         kind_q  <= ENC_R;
         op_q    <= '0;
         f3_q    <= '0;
         f7_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         li_q    <= 1'b0;
         small_q <= 1'b0;
         nop_q   <= 1'b0;
         hi20_q  <= '0;
         lo12_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         if (accept) begin
            kind_q  <= kind_in;
            op_q    <= req_opcode;
            f3_q    <= req_f3;
            f7_q    <= req_f7;
            rd_q    <= req_rd;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            imm_q   <= req_imm;
            li_q    <= li_in;
            small_q <= small_d;
            nop_q   <= nop_d;
            hi20_q  <= hi20_d;
            lo12_q  <= lo12_d;
            mask_q  <= mask_d;
         end
      end
   end

   enc_kind_t   f_kind;
   logic [6:0]  f_op, f_f7;
   logic [2:0]  f_f3;
   logic [4:0]  f_rd, f_rs1, f_rs2;
   logic [63:0] f_imm;
   logic [31:0] fmt_word;
   logic        fmt_err;

   // LI steps all write rd; every step after lui reads rd back, except the small form.
   always_comb begin
      f_kind = kind_q;
      f_op   = op_q;
      f_f3   = f3_q;
      f_f7   = f7_q;
      f_rd   = rd_q;
      f_rs1  = rs1_q;
      f_rs2  = rs2_q;
      f_imm  = imm_q;
      if (li_q) begin
         f_kind = ENC_I;
         f_op   = OPC_OPIMM;
         f_f3   = 3'd0;
         f_f7   = '0;
         f_rs1  = rd_q;
         f_rs2  = '0;
         case (step_q)
            LI_LUI: begin
               f_kind = ENC_U;
               f_op   = OPC_LUI;
               f_imm  = {{32{hi20_q[19]}}, hi20_q, 12'h000};
            end
            LI_ADDIW: begin
               f_op  = OPC_OPIMM32;
               f_imm = sext12(lo12_q);
            end
            LI_SLLI11A, LI_SLLI11B: begin
               f_f3  = 3'd1;
               f_imm = 64'd11;
            end
            LI_SLLI10: begin
               f_f3  = 3'd1;
               f_imm = 64'd10;
            end
            LI_ADDI_C2: f_imm = {53'd0, imm_q[31:21]};
            LI_ADDI_C1: f_imm = {53'd0, imm_q[20:10]};
            default: begin
               if (small_q) begin
                  f_rs1 = '0;
                  f_imm = sext12(lo12_q);
               end else begin
                  f_imm = {54'd0, imm_q[9:0]};
               end
            end
         endcase
      end
   end

   instr_format u_format (
      .kind_i   (f_kind),
      .opcode_i (f_op),
      .f3_i     (f_f3),
      .f7_i     (f_f7),
      .rd_i     (f_rd),
      .rs1_i    (f_rs1),
      .rs2_i    (f_rs2),
      .imm_i    (f_imm),
      .word_o   (fmt_word),
      .err_o    (fmt_err)
   );

   assign instr_valid = emit;
   assign instr       = !emit ? 32'h0 : (nop_q ? NOP_INSTR : fmt_word);
   assign instr_last  = emit && last;
   assign instr_err   = emit && fmt_err && !li_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a spec-level encoding model.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, req_valid, req_ready, instr_valid, instr_ready, instr_last, instr_err;
   logic        req_valid1, req_ready1, instr_valid1, instr_ready1, instr_last1, instr_err1;
   logic [2:0]  req_kind, req_f3;
   logic [6:0]  req_opcode, req_f7;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [63:0] req_imm;
   logic [31:0] instr, instr1;

   instr_encoder #(.SKIP_ZERO(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_opcode(req_opcode), .req_f3(req_f3), .req_f7(req_f7),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_last(instr_last), .instr_err(instr_err));

   instr_encoder #(.SKIP_ZERO(1'b0)) dut_nz (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_kind(req_kind), .req_opcode(req_opcode), .req_f3(req_f3), .req_f7(req_f7),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .instr_valid(instr_valid1), .instr_ready(instr_ready1), .instr(instr1),
      .instr_last(instr_last1), .instr_err(instr_err1));

   typedef struct {
      logic [2:0]  kind;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      int          nfix;
      logic [31:0] fix[4];
      bit          fixerr;
   } req_t;

   int          n_tests, n_fail;
   logic [31:0] mw[$];
   bit          merr;
   logic [31:0] exp_w[$];
   bit          exp_l[$], exp_e[$];
   req_t        dir[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit fits(input logic [63:0] x, input int bits);
      longint v, lim;
      v   = longint'(x);
      lim = longint'(1) << (bits - 1);
      return (v >= -lim) && (v < lim);
   endfunction

   function automatic logic [31:0] i_word(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   // Expected word list for one request, straight from the format and LI rules.
   function automatic void model(input req_t r, input bit skip);
      mw.delete();
      merr = 1'b0;
      case (r.kind)
         ENC_R: mw.push_back({r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op});
         ENC_I: begin
            mw.push_back(i_word(r.imm[11:0], r.rs1, r.f3, r.rd, r.op));
            merr = RC && !fits(r.imm, 12);
         end
         ENC_S: begin
            mw.push_back({r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op});
            merr = RC && !fits(r.imm, 12);
         end
         ENC_B: begin
            mw.push_back({r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op});
            merr = RC && !fits(r.imm, 13);
         end
         ENC_U: begin
            mw.push_back({r.imm[31:12], r.rd, r.op});
            merr = RC && !fits(r.imm, 32);
         end
         ENC_J: begin
            mw.push_back({r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op});
            merr = RC && !fits(r.imm, 21);
         end
         default: begin
            if (r.rd == 0) mw.push_back(32'h0000_0013);
            else if (fits(r.imm, 12)) mw.push_back(i_word(r.imm[11:0], 5'd0, 3'd0, r.rd, 7'h13));
            else begin
               logic [31:0] u;
               logic [19:0] hi;
               logic [11:0] ch[3];
               u  = fits(r.imm, 32) ? r.imm[31:0] : r.imm[63:32];
               hi = 20'((u + 32'h800) >> 12);
               mw.push_back({hi, r.rd, 7'h37});
               if (!(skip && u[11:0] == 0)) mw.push_back(i_word(u[11:0], r.rd, 3'd0, r.rd, 7'h1B));
               if (!fits(r.imm, 32)) begin
                  ch[0] = 12'((r.imm >> 21) & 64'h7FF);
                  ch[1] = 12'((r.imm >> 10) & 64'h7FF);
                  ch[2] = 12'(r.imm & 64'h3FF);
                  for (int k = 0; k < 3; k++) begin
                     mw.push_back(i_word((k == 2) ? 12'd10 : 12'd11, r.rd, 3'd1, r.rd, 7'h13));
                     if (!(skip && ch[k] == 0)) mw.push_back(i_word(ch[k], r.rd, 3'd0, r.rd, 7'h13));
                  end
               end
            end
         end
      endcase
   endfunction

   function automatic logic [63:0] rand_imm();
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = $urandom;
      case ($urandom_range(0, 4))
         0: return {{52{a[11]}}, a[11:0]};
         1: return {{32{a[31]}}, a};
         2: return {b, a};
         3: begin
            if (c[0]) a[31:21] = '0;
            if (c[1]) a[20:10] = '0;
            if (c[2]) a[9:0]   = '0;
            if (c[3]) b[11:0]  = '0;
            return {b, a};
         end
         default: case ($urandom_range(0, 8))
            0: return 64'h7FF;
            1: return 64'h800;
            2: return 64'hFFFF_FFFF_FFFF_F800;
            3: return 64'hFFFF_FFFF_FFFF_F7FF;
            4: return 64'h7FFF_FFFF;
            5: return 64'h8000_0000;
            6: return 64'hFFFF_FFFF_8000_0000;
            7: return 64'h1000;
            default: return 64'h10_0000;
         endcase
      endcase
   endfunction

   function automatic req_t mk(input logic [2:0] kind, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [63:0] imm);
      req_t r;
      r.kind = kind; r.op = op; r.f3 = f3; r.f7 = f7;
      r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
      r.nfix = 0; r.fixerr = 1'b0;
      for (int k = 0; k < 4; k++) r.fix[k] = '0;
      return r;
   endfunction

   function automatic req_t rand_req();
      logic [2:0] k;
      k = $urandom_range(0, 1) ? 3'(ENC_LI) : 3'($urandom_range(0, 5));
      return mk(k, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), rand_imm());
   endfunction

   task automatic drive(input req_t r);
      req_kind = r.kind; req_opcode = r.op; req_f3 = r.f3; req_f7 = r.f7;
      req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
   endtask

   // One process drives requests and checks outputs against the expected-word FIFO.
   task automatic run_stream(input int nreq, input int rdy_pct);
      int   issued, guard;
      bit   have;
      req_t cur;
      issued = 0; guard = 0; have = 1'b0;
      while ((issued < nreq || have || exp_w.size() != 0) && guard < 20000) begin
         @(negedge clk);
         guard++;
         instr_ready = ($urandom_range(0, 99) < rdy_pct);
         if (!have && issued < nreq) begin
            cur  = (dir.size() != 0) ? dir.pop_front() : rand_req();
            have = 1'b1;
            issued++;
         end
         req_valid = have && ($urandom_range(0, 3) != 0);
         if (have) drive(cur);
         #1;
         chk("valid", instr_valid, exp_w.size() != 0);
         if (instr_valid && exp_w.size() != 0) begin
            chk("word", instr, exp_w[0]);
            chk("last", instr_last, exp_l[0]);
            chk("err", instr_err, exp_e[0]);
            if (instr_ready) begin
               void'(exp_w.pop_front()); void'(exp_l.pop_front()); void'(exp_e.pop_front());
            end
         end
         if (req_valid && req_ready) begin
            if (cur.nfix != 0) begin
               for (int k = 0; k < cur.nfix; k++) begin
                  exp_w.push_back(cur.fix[k]); exp_l.push_back(k == cur.nfix - 1);
                  exp_e.push_back(cur.fixerr);
               end
            end else begin
               model(cur, 1'b1);
               foreach (mw[k]) begin
                  exp_w.push_back(mw[k]); exp_l.push_back(k == mw.size() - 1);
                  exp_e.push_back(merr);
               end
            end
            have = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("stream_timeout", guard >= 20000, 0);
   endtask

   initial begin
      req_t r;
      n_tests = 0; n_fail = 0;
      reset_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
      instr_ready = 1'b0; instr_ready1 = 1'b0;
      drive(mk(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0));
      #12;
      chk("rst_valid", instr_valid, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_instr", instr, 0);
      chk("rst_last", instr_last, 0);
      chk("rst_err", instr_err, 0);
      chk("rst_valid_nz", instr_valid1, 0);
      @(negedge clk);
      reset_n = 1'b1;

      r = mk(ENC_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
      r.nfix = 1; r.fix[0] = 32'h0020_81B3; dir.push_back(r);
      r = mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
      r.nfix = 2; r.fix[0] = 32'h1234_52B7; r.fix[1] = 32'h6782_829B; dir.push_back(r);
      r = mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      r.nfix = 1; r.fix[0] = 32'hFFF0_0093; dir.push_back(r);
      r = mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, {$urandom, $urandom});
      r.nfix = 1; r.fix[0] = 32'h0000_0013; dir.push_back(r);
      r = mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 64'h8000_0000_0000_0000);
      r.nfix = 4; r.fix[0] = 32'h8000_0337; r.fix[1] = 32'h00B3_1313;
      r.fix[2] = 32'h00B3_1313; r.fix[3] = 32'h00A3_1313; dir.push_back(r);
      r = mk(ENC_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 64'h800);
      r.nfix = 1; r.fix[0] = 32'h8001_0093; r.fixerr = RC; dir.push_back(r);

      run_stream(256, 70);
      run_stream(120, 30);

      // Backpressure hold, then reset in the middle of an LI sequence.
      @(negedge clk);
      drive(mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 64'h8000_0000_0000_0000));
      req_valid = 1'b1; instr_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_valid", instr_valid, 1);
      chk("bp_w0", instr, 32'h8000_0337);
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold", instr, 32'h8000_0337);
         chk("bp_hold_last", instr_last, 0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      chk("bp_w1", instr, 32'h00B3_1313);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", instr_valid, 0);
      chk("mid_rst_ready", req_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_idle", instr_valid, 0);
      end

      // SKIP_ZERO=0 instance: all eight steps appear.
      r = mk(ENC_LI, 7'd0, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 64'h8000_0000_0000_0000);
      model(r, 1'b0);
      drive(r);
      req_valid1 = 1'b1; instr_ready1 = 1'b1;
      @(negedge clk);
      req_valid1 = 1'b0;
      foreach (mw[k]) begin
         chk("nz_word", instr1, mw[k]);
         chk("nz_last", instr_last1, k == mw.size() - 1);
         @(negedge clk);
      end
      chk("nz_idle", instr_valid1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder: turns structured encode requests into raw RV64 32-bit instruction words.
- Expands the LI pseudo-op (load a 64-bit immediate into rd) into a multi-word lui/addiw/slli/addi sequence.
- Feeds the self-test and boot injection path ahead of fetch; a valid/ready stream on both sides.

Parameters:
- SKIP_ZERO, 1, when 1 omit any addiw/addi step of an LI expansion whose immediate is zero.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_kind  in  3  enc_kind_t: ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J, ENC_LI
- req_opcode  in  7  opcode field, ignored for ENC_LI
- req_f3  in  3  funct3, R/I/S/B only
- req_f7  in  7  funct7, R only
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  64  immediate, byte offset for B/J
- instr_valid  out  1  output word valid
- instr_ready  in  1  downstream accepts
- instr  out  32  encoded word
- instr_last  out  1  final word of the current request
- instr_err  out  1  immediate out of range (optional feature only)

Behaviour:
Reset:
- Asynchronous on reset_n low: FSM to IDLE, step counter 0, instr_valid/instr/instr_last/instr_err 0.
- req_ready is combinational: high in IDLE.
- Reset mid-sequence drops the remaining words of that request.

FSM:
- IDLE: req_ready=1. On accept, latch the request, compute the step plan, go to EMIT. instr_valid rises in the next cycle (1-cycle latency).
- EMIT: instr_valid=1. instr, instr_last and instr_err are held stable while instr_ready=0.
  - On a handshake of a non-last word, advance to the next non-skipped step.
  - On a handshake of the last word, return to IDLE. In that same cycle req_ready=1, so a new request may be accepted, giving back-to-back output with no bubble.

Formats (standard RV layouts):
- R: {f7,rs2,rs1,f3,rd,op}
- I: {imm[11:0],rs1,f3,rd,op}
- S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
- B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
- U: {imm[31:12],rd,op}
- J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- imm[0] is ignored for B/J. Non-LI requests produce one word, always last.

ENC_LI plan, selected in priority order:
- rd==0: emit one NOP 0x00000013.
- imm[63:11] all equal: emit addi rd,x0,imm[11:0].
- imm[63:31] all equal:
  - hi20=(imm[31:0]+0x800)>>12, truncated to 20 bits; lo=imm[11:0].
  - Emit lui rd,hi20, then addiw rd,rd,lo.
  - addiw is skipped when lo==0 and SKIP_ZERO=1.
- Otherwise, with u=imm[63:32]:
  - Emit lui/addiw for u, using the 32-bit rule above.
  - Then: slli 11; addi imm[31:21]; slli 11; addi imm[20:10]; slli 10; addi imm[9:0].
  - Each addi chunk is non-negative, so there is no carry.
  - Maximum 8 words. Zero addiw/addi steps are skipped when SKIP_ZERO=1; slli steps are never skipped.
- Opcodes: LUI 0x37, OP-IMM 0x13, OP-IMM-32 0x1B. slli uses funct6 0 and f3 1.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Defined: instr_err=1 with a word whose source immediate does not fit its field:
  - I/S: imm not sign-extended from bit 11.
  - B: not sign-extended from bit 12.
  - J: not sign-extended from bit 20.
  - U: not sign-extended from bit 31.
  - The word is still emitted, truncated. LI never errs.
- Undefined: instr_err tied 0; range logic absent.

Decomposition:
- Shared package holds:
  - enc_kind_t
  - opcode constants OPC_LUI/OPC_OPIMM/OPC_OPIMM32
  - NOP_INSTR
  - li_step_t enum: LI_LUI, LI_ADDIW, LI_SLLI11A, LI_ADDI_C2, LI_SLLI11B, LI_ADDI_C1, LI_SLLI10, LI_ADDI_C0
- One sub-module, instr_format: combinational field packer (kind, fields, imm → 32-bit word), reused by each step.

Test Plan:
- ENC_R op 0x33, f3 0, f7 0, rd3 rs1 1 rs2 2 → one word 0x002081B3, instr_last=1, valid 1 cycle after accept.
- ENC_LI rd5 imm 0x12345678 → 0x123452B7 then 0x6782829B, last on second.
- ENC_LI rd1 imm -1 → single 0xFFF00093; ENC_LI rd0 any imm → single 0x00000013.
- ENC_LI rd6 imm 0x8000000000000000, SKIP_ZERO=1 → 0x80000337, 0x00B31313, 0x00B31313, 0x00A31313; SKIP_ZERO=0 → 8 words with zero addiw/addi.
- Backpressure and reset:
  - Hold instr_ready=0 for 3 cycles mid-LI → word stable.
  - Queue a new request during the last word → accepted on that handshake with no bubble.
  - reset_n low mid-sequence → instr_valid 0 immediately, IDLE.
- With the macro: ENC_I imm 0x800 → instr_err=1, word imm field 0x800. Without the macro: instr_err=0.
